rng_word_buffer: RTL and testbench

Downstream stage of the Von Neumann corrector in the ring-oscillator RNG datapath. It accepts the corrector's qualified output bits and packs them LSB-first into WORD_W-bit words. Completed words are buffered in a DEPTH-entry first-word-fall-through FIFO and offered on a valid/ready port. A repetition-count health test on the incoming bit stream raises a sticky alarm and shuts off output when the entropy source sticks.

---
 rtl/rng_word_buffer.sv | 158 +++++++++++++++
 tb/tb_rng_word_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rng_word_buffer.sv
// Packs qualified corrector bits LSB-first into words, buffers them in a
// first-word-fall-through FIFO and guards the stream with a repetition-count test.
module rng_word_buffer #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RCT_LIMIT = 32
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  input  logic                         clr,
  output logic [WORD_W-1:0]            word_out,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         alarm
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned BitW = $clog2(WORD_W);
  localparam int unsigned RunW = $clog2(RCT_LIMIT + 1);

  localparam logic [BitW-1:0] LastBit  = BitW'(WORD_W - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(DEPTH);
  localparam logic [RunW-1:0] RunLimit = RunW'(RCT_LIMIT);

  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RunW-1:0]   run_q, run_d;
  logic              last_q, last_d;
  logic              ovf_q, ovf_d;
  logic              alarm_q, alarm_d;

  logic [WORD_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              pop;
  logic              push;
  logic              push_ok;
  logic              trip;
  logic              same_bit;
  logic [RunW-1:0]   run_next;
  logic [WORD_W-1:0] word_next;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    last_d    = last_q;
    ovf_d     = ovf_q;
    alarm_d   = alarm_q;
    push      = 1'b0;
    push_ok   = 1'b0;

    accept   = bit_valid && !alarm_q;
    pop      = word_valid && word_ready;
    // run_q == 0 marks "no bit seen yet since reset/clr"
    same_bit = (run_q != '0) && (bit_in == last_q);
    if (!same_bit) begin
      run_next = RunW'(1);
    end else if (run_q == '1) begin
      run_next = run_q;
    end else begin
      run_next = run_q + 1'b1;
    end
    trip = accept && (run_next == RunLimit);

    word_next            = shift_q;
    word_next[bit_cnt_q] = bit_in;

    if (trip) begin
      // Tripping bit, partial word and all queued words are discarded.
      alarm_d   = 1'b1;
      bit_cnt_d = '0;
      shift_d   = '0;
      wptr_d    = '0;
      rptr_d    = '0;
      cnt_d     = '0;
    end else begin
      if (accept) begin
        run_d  = run_next;
        last_d = bit_in;
        if (bit_cnt_q == LastBit) begin
          bit_cnt_d = '0;
          shift_d   = '0;
          push      = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shift_d   = word_next;
        end
      end

      if (push) begin
        if ((cnt_q == FullCnt) && !pop) begin
          ovf_d = 1'b1;
        end else begin
          push_ok = 1'b1;
          wptr_d  = wptr_q + 1'b1;
        end
      end

      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end

      cnt_d = cnt_q + CntW'(push_ok) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b || clr) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      run_q     <= '0;
      last_q    <= 1'b0;
      ovf_q     <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
      alarm_q   <= alarm_d;
    end
  end

  // Storage needs no reset: word_out is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst_b && !clr && push_ok) begin
      mem_q[wptr_q] <= word_next;
    end
  end

  always_comb begin
    word_valid = (cnt_q != '0) && !alarm_q;
    word_out   = word_valid ? mem_q[rptr_q] : '0;
    count      = cnt_q;
    overflow   = ovf_q;
    alarm      = alarm_q;
  end

endmodule

// File: tb/tb_rng_word_buffer.sv
// Randomised and directed bench for rng_word_buffer: a bit/word-level model feeds a
// scoreboard queue that an independent monitor drains on every output handshake.
module tb_rng_word_buffer;

  localparam int W = 8;
  localparam int D = 4;
  localparam int L = 32;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         clr = 1'b0;
  logic         word_ready = 1'b0;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic [2:0]   count;
  logic         overflow;
  logic         alarm;

  rng_word_buffer #(
    .WORD_W   (W),
    .DEPTH    (D),
    .RCT_LIMIT(L)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clr       (clr),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .count     (count),
    .overflow  (overflow),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] sb [$];

  // Reference model state
  bit m_bits [$];
  int m_cnt   = 0;
  int m_run   = 0;
  bit m_last  = 1'b0;
  bit m_alarm = 1'b0;
  bit m_ovf   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rb, input bit c, input bit bv, input bit b, input bit rdy);
    bit           pop;
    bit           push;
    logic [W-1:0] word;
    int           nr;
    if (!rb || c) begin
      m_bits.delete();
      m_cnt = 0; m_run = 0; m_last = 1'b0; m_alarm = 1'b0; m_ovf = 1'b0;
      sb.delete();
      return;
    end
    if (m_alarm) return;
    pop  = (m_cnt > 0) && rdy;
    push = 1'b0;
    word = '0;
    if (bv) begin
      nr = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
      if (nr >= L) begin
        m_alarm = 1'b1;
        m_bits.delete();
        m_cnt = 0;
        sb.delete();
        return;
      end
      m_run  = nr;
      m_last = b;
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) word[i] = m_bits[i];
        m_bits.delete();
        push = 1'b1;
      end
    end
    if (push) begin
      if (m_cnt == D && !pop) m_ovf = 1'b1;
      else begin
        sb.push_back(word);
        m_cnt++;
      end
    end
    if (pop) m_cnt--;
  endtask

  task automatic check_outputs();
    bit exp_valid;
    exp_valid = (m_cnt > 0) && !m_alarm;
    chk("count", 32'(count), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("alarm", 32'(alarm), 32'(m_alarm));
    chk("word_valid", 32'(word_valid), 32'(exp_valid));
    if (!exp_valid) chk("word_out_idle", 32'(word_out), 32'h0);
  endtask

  task automatic step(input bit rb, input bit c, input bit bv, input bit b, input bit rdy);
    @(negedge clk);
    rst_b = rb; clr = c; bit_valid = bv; bit_in = b; word_ready = rdy;
    @(posedge clk);
    #1;
    model_edge(rb, c, bv, b, rdy);
    check_outputs();
  endtask

  task automatic send_word(input logic [W-1:0] v, input bit rdy, input bit gap,
                           input bit last_rdy);
    logic [W-1:0] w;
    w = v;
    for (int i = 0; i < W; i++) begin
      step(1'b1, 1'b0, 1'b1, w[i], (i == W - 1) ? last_rdy : rdy);
      if (gap && i != W - 1) step(1'b1, 1'b0, 1'b0, 1'($urandom_range(1)), rdy);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  // Monitor: just before each edge, a handshake must match the scoreboard head.
  always @(negedge clk) begin
    logic [W-1:0] exp;
    #4;
    if (word_valid === 1'b1 && word_ready === 1'b1 && rst_b === 1'b1 && clr === 1'b0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got word %0h expected no word at %0t", word_out, $time);
      end else begin
        exp = sb.pop_front();
        chk("word_out", 32'(word_out), 32'(exp));
      end
    end
  end

  initial begin
    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Packing order
    send_word(8'h4D, 1'b1, 1'b0, 1'b1);
    chk("pack_word", 32'(word_out), 32'h4D);
    chk("pack_count", 32'(count), 32'd1);
    idle(2, 1'b1);

    // Backpressure and overflow, then drain
    send_word(8'h4D, 1'b0, 1'b0, 1'b0);
    send_word(8'hB2, 1'b0, 1'b0, 1'b0);
    send_word(8'h4D, 1'b0, 1'b0, 1'b0);
    send_word(8'hB2, 1'b0, 1'b0, 1'b0);
    send_word(8'h55, 1'b0, 1'b0, 1'b0);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    idle(6, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Full with simultaneous pop and push
    send_word(8'h4D, 1'b0, 1'b0, 1'b0);
    send_word(8'hB2, 1'b0, 1'b0, 1'b0);
    send_word(8'h4D, 1'b0, 1'b0, 1'b0);
    send_word(8'hB2, 1'b0, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0, 1'b1);
    chk("full_pp_count", 32'(count), 32'd4);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    idle(6, 1'b1);

    // Gapped input
    send_word(8'h4D, 1'b0, 1'b1, 1'b0);
    chk("gap_word", 32'(word_out), 32'h4D);
    idle(2, 1'b1);

    // Repetition-count test
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < L - 1; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rct_pre_alarm", 32'(alarm), 32'd0);
    chk("rct_pre_count", 32'(count), 32'd3);
    chk("rct_pre_word", 32'(word_out), 32'hFF);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rct_alarm", 32'(alarm), 32'd1);
    chk("rct_count", 32'(count), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'(i), 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'h4D, 1'b0, 1'b0, 1'b0);
    chk("rct_after_clr", 32'(word_out), 32'h4D);

    // Reset mid-operation
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'h12, 1'b0, 1'b0, 1'b0);
    send_word(8'h34, 1'b0, 1'b0, 1'b0);
    send_word(8'h56, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("rst_fresh_word", 32'(word_out), 32'hA5);
    chk("rst_fresh_count", 32'(count), 32'd1);

    // Randomised phases with increasingly biased bits
    for (int ph = 0; ph < 3; ph++) begin
      int p;
      p = (ph == 0) ? 50 : (ph == 1) ? 90 : 98;
      for (int i = 0; i < 400; i++) begin
        step(($urandom_range(499) != 0), ($urandom_range(199) == 0),
             ($urandom_range(3) != 0), ($urandom_range(99) < p), 1'($urandom_range(1)));
      end
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle(6, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
